// File: rtl/midi_note_receiver.sv
// MIDI note-on/note-off receiver: a UART byte receiver feeding a status/note/velocity parser.
// Define MIDI_RX_RUNNING_STATUS_EN to keep the last note status active across messages (running status).
module midi_note_receiver #(
  parameter int          CLK_FREQ     = 100_000_000,
  parameter int          BAUD         = 31250,
  parameter logic [3:0]  MIDI_CHANNEL = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       note_valid,
  output logic       note_on,
  output logic [6:0] note,
  output logic [6:0] velocity,
  output logic       framing_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;
  typedef enum logic [1:0] {WAIT_STATUS, WAIT_NOTE, WAIT_VEL} parse_state_t;

  logic             rx_meta_reg, rx_sync_reg, rx_prev_reg;
  uart_state_t      uart_state_reg, uart_state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       bit_idx_reg, bit_idx_next;
  logic [7:0]       shift_reg, shift_next;
  logic             sample_tick, byte_valid;

  parse_state_t     parse_state_reg, parse_state_next;
  logic             type_valid_reg, type_valid_next;
  logic             type_on_reg, type_on_next;
  logic [6:0]       note_tmp_reg, note_tmp_next;
  logic             note_valid_reg, note_valid_next;
  logic             note_on_reg, note_on_next;
  logic [6:0]       note_reg, note_next;
  logic [6:0]       velocity_reg, velocity_next;

  // rx_prev_reg keeps the previous synchronized level for start-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_sync_reg <= rx_meta_reg;
      rx_prev_reg <= rx_sync_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uart_state_reg <= U_IDLE;
      cnt_reg        <= '0;
      bit_idx_reg    <= '0;
      shift_reg      <= '0;
    end else begin
      uart_state_reg <= uart_state_next;
      cnt_reg        <= cnt_next;
      bit_idx_reg    <= bit_idx_next;
      shift_reg      <= shift_next;
    end
  end

  always_comb begin
    uart_state_next = uart_state_reg;
    cnt_next        = cnt_reg + 1'b1;
    bit_idx_next    = bit_idx_reg;
    shift_next      = shift_reg;
    byte_valid      = 1'b0;
    framing_err     = 1'b0;
    sample_tick     = (cnt_reg == ((uart_state_reg == U_START) ? HALF_LAST : BIT_LAST));
    case (uart_state_reg)
      U_IDLE: begin
        cnt_next = '0;
        if (!rx_sync_reg && rx_prev_reg) uart_state_next = U_START;
      end
      U_START: if (sample_tick) begin
        cnt_next        = '0;
        bit_idx_next    = '0;
        uart_state_next = rx_sync_reg ? U_IDLE : U_DATA;
      end
      U_DATA: if (sample_tick) begin
        cnt_next     = '0;
        shift_next   = {rx_sync_reg, shift_reg[7:1]};
        bit_idx_next = bit_idx_reg + 1'b1;
        if (bit_idx_reg == 3'd7) uart_state_next = U_STOP;
      end
      U_STOP: if (sample_tick) begin
        cnt_next        = '0;
        uart_state_next = U_IDLE;
        byte_valid      = rx_sync_reg;
        framing_err     = !rx_sync_reg;
      end
      default: uart_state_next = U_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parse_state_reg <= WAIT_STATUS;
      type_valid_reg  <= 1'b0;
      type_on_reg     <= 1'b0;
      note_tmp_reg    <= '0;
      note_valid_reg  <= 1'b0;
      note_on_reg     <= 1'b0;
      note_reg        <= '0;
      velocity_reg    <= '0;
    end else begin
      parse_state_reg <= parse_state_next;
      type_valid_reg  <= type_valid_next;
      type_on_reg     <= type_on_next;
      note_tmp_reg    <= note_tmp_next;
      note_valid_reg  <= note_valid_next;
      note_on_reg     <= note_on_next;
      note_reg        <= note_next;
      velocity_reg    <= velocity_next;
    end
  end

  // Real-time bytes (0xF8-0xFF) fall through every branch and leave the parser untouched.
  always_comb begin
    parse_state_next = parse_state_reg;
    type_valid_next  = type_valid_reg;
    type_on_next     = type_on_reg;
    note_tmp_next    = note_tmp_reg;
    note_valid_next  = 1'b0;
    note_on_next     = note_on_reg;
    note_next        = note_reg;
    velocity_next    = velocity_reg;
    if (byte_valid && shift_reg < 8'hF8) begin
      if (shift_reg[7]) begin
        if (shift_reg[7:5] == 3'b100 && shift_reg[3:0] == MIDI_CHANNEL) begin
          type_valid_next  = 1'b1;
          type_on_next     = shift_reg[4];
          parse_state_next = WAIT_NOTE;
        end else begin
          type_valid_next  = 1'b0;
          parse_state_next = WAIT_STATUS;
        end
      end else begin
        case (parse_state_reg)
          WAIT_STATUS: begin
`ifdef MIDI_RX_RUNNING_STATUS_EN
            if (type_valid_reg) begin
              note_tmp_next    = shift_reg[6:0];
              parse_state_next = WAIT_VEL;
            end
`endif
          end
          WAIT_NOTE: begin
            note_tmp_next    = shift_reg[6:0];
            parse_state_next = WAIT_VEL;
          end
          WAIT_VEL: begin
            note_valid_next = 1'b1;
            note_next       = note_tmp_reg;
            velocity_next   = shift_reg[6:0];
            note_on_next    = type_on_reg && (shift_reg[6:0] != 7'd0);
`ifdef MIDI_RX_RUNNING_STATUS_EN
            parse_state_next = WAIT_NOTE;
`else
            parse_state_next = WAIT_STATUS;
            type_valid_next  = 1'b0;
`endif
          end
          default: parse_state_next = WAIT_STATUS;
        endcase
      end
    end
  end

  assign note_valid = note_valid_reg;
  assign note_on    = note_on_reg;
  assign note       = note_reg;
  assign velocity   = velocity_reg;

endmodule

// File: tb/tb_midi_note_receiver.sv
// Directed bench for midi_note_receiver: serial bytes in, expected note reports queued and popped on note_valid.
module tb_midi_note_receiver;

  localparam int BAUD         = 31250;
  localparam int CLK_FREQ     = BAUD * 16;
  localparam int CPB          = CLK_FREQ / BAUD;
  // Start edge driven before posedge k -> note_valid seen after posedge k + 9*CPB + CPB/2 + 2.
  localparam int LATENCY      = 9 * CPB + CPB / 2 + 3;

  typedef struct packed {
    logic       on;
    logic [6:0] n;
    logic [6:0] v;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       note_valid, note_on, framing_err;
  logic [6:0] note, velocity;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   fe_cnt = 0;
  int   pulse_cnt = 0;
  exp_t exp_q[$];
  exp_t last_exp = '0;
  logic nv_prev  = 1'b0;
  logic lat_armed = 1'b0;
  int   lat_c0   = 0;

  midi_note_receiver #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .MIDI_CHANNEL(4'd0)) dut (
    .clk(clk), .rst(rst), .rx(rx), .note_valid(note_valid), .note_on(note_on),
    .note(note), .velocity(velocity), .framing_err(framing_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (framing_err) fe_cnt++;
    if (note_valid) begin
      exp_t e;
      pulse_cnt++;
      check("pulse_single_cycle", 32'(nv_prev), 32'd0);
      check("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        $display("note_valid: on=%0d note=%02h vel=%02h (expected on=%0d note=%02h vel=%02h)",
                 note_on, note, velocity, e.on, e.n, e.v);
        check("note_on", 32'(note_on), 32'(e.on));
        check("note", 32'(note), 32'(e.n));
        check("velocity", 32'(velocity), 32'(e.v));
      end
      if (lat_armed) begin
        check("latency", 32'(cyc - lat_c0), 32'(LATENCY));
        lat_armed = 1'b0;
      end
    end
    nv_prev = note_valid;
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_bit);
    rx = 1'b1;
  endtask

  task automatic expect_note(input logic on, input logic [6:0] n, input logic [6:0] v);
    exp_t e;
    e.on = on; e.n = n; e.v = v;
    exp_q.push_back(e);
    last_exp = e;
  endtask

  task automatic settle(input string tag);
    repeat (3 * CPB) @(negedge clk);
    check(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    repeat (4) @(negedge clk);
    check("rst_note_valid", 32'(note_valid), 32'd0);
    check("rst_note_on", 32'(note_on), 32'd0);
    check("rst_note", 32'(note), 32'd0);
    check("rst_velocity", 32'(velocity), 32'd0);
    check("rst_framing_err", 32'(framing_err), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Basic note-on, with latency measured from the velocity byte's start edge
    expect_note(1'b1, 7'h3C, 7'h64);
    send_byte(8'h90, 1'b1);
    send_byte(8'h3C, 1'b1);
    lat_c0 = cyc; lat_armed = 1'b1;
    send_byte(8'h64, 1'b1);
    settle("s1_all_reported");
    check("s1_latency_seen", 32'(lat_armed), 32'd0);

    // Note-off, and note-on with zero velocity
    expect_note(1'b0, 7'h40, 7'h00);
    send_byte(8'h80, 1'b1); send_byte(8'h40, 1'b1); send_byte(8'h00, 1'b1);
    expect_note(1'b0, 7'h40, 7'h00);
    send_byte(8'h90, 1'b1); send_byte(8'h40, 1'b1); send_byte(8'h00, 1'b1);
    settle("s2_all_reported");

    // Other channel ignored
    pulse_cnt = 0;
    send_byte(8'h91, 1'b1); send_byte(8'h3C, 1'b1); send_byte(8'h64, 1'b1);
    repeat (3 * CPB) @(negedge clk);
    check("s3_other_channel_pulses", 32'(pulse_cnt), 32'd0);
    expect_note(1'b1, 7'h3E, 7'h50);
    send_byte(8'h90, 1'b1); send_byte(8'h3E, 1'b1); send_byte(8'h50, 1'b1);
    settle("s3_all_reported");

    // Real-time byte mid-message; new status aborts a partial message
    pulse_cnt = 0;
    expect_note(1'b1, 7'h3C, 7'h64);
    send_byte(8'h90, 1'b1); send_byte(8'h3C, 1'b1); send_byte(8'hF8, 1'b1); send_byte(8'h64, 1'b1);
    expect_note(1'b1, 7'h3E, 7'h20);
    send_byte(8'h90, 1'b1); send_byte(8'h3C, 1'b1);
    send_byte(8'h90, 1'b1); send_byte(8'h3E, 1'b1); send_byte(8'h20, 1'b1);
    settle("s4_all_reported");
    check("s4_pulse_count", 32'(pulse_cnt), 32'd2);

    // Framing error
    fe_cnt = 0; pulse_cnt = 0;
    send_byte(8'h55, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    check("s5_framing_pulses", 32'(fe_cnt), 32'd1);
    check("s5_no_note", 32'(pulse_cnt), 32'd0);
    check("s5_hold_note", 32'(note), 32'h3E);
    check("s5_hold_velocity", 32'(velocity), 32'h20);

    // Reset in the middle of a byte
    rx = 1'b0; repeat (CPB) @(negedge clk);
    rx = 1'b0; repeat (2 * CPB) @(negedge clk);
    rst = 1'b1; rx = 1'b1;
    repeat (5) @(negedge clk);
    check("s6_rst_note", 32'(note), 32'd0);
    check("s6_rst_velocity", 32'(velocity), 32'd0);
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    pulse_cnt = 0;
    expect_note(1'b1, 7'h30, 7'h10);
    send_byte(8'h90, 1'b1); send_byte(8'h30, 1'b1); send_byte(8'h10, 1'b1);
    settle("s6_all_reported");
    check("s6_pulse_count", 32'(pulse_cnt), 32'd1);

    // Running status behaviour
    pulse_cnt = 0;
    expect_note(1'b1, 7'h3C, 7'h64);
    send_byte(8'h90, 1'b1); send_byte(8'h3C, 1'b1); send_byte(8'h64, 1'b1);
`ifdef MIDI_RX_RUNNING_STATUS_EN
    expect_note(1'b1, 7'h3E, 7'h50);
`endif
    send_byte(8'h3E, 1'b1); send_byte(8'h50, 1'b1);
    settle("s7_all_reported");
`ifdef MIDI_RX_RUNNING_STATUS_EN
    check("s7_pulse_count", 32'(pulse_cnt), 32'd2);
`else
    check("s7_pulse_count", 32'(pulse_cnt), 32'd1);
`endif

    // Outputs hold after the last report
    repeat (2 * CPB) @(negedge clk);
    check("hold_note_on", 32'(note_on), 32'(last_exp.on));
    check("hold_note", 32'(note), 32'(last_exp.n));
    check("hold_velocity", 32'(velocity), 32'(last_exp.v));
    check("hold_note_valid_low", 32'(note_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/midi_note_receiver.md
MIDI_NOTE_RECEIVER -- requirements
Module: midi_note_receiver

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 31250, MIDI serial bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (3200 at defaults).
REQ-003 SHALL have parameter MIDI_CHANNEL, default 4'd0, the only channel whose note messages are reported.
REQ-004 clk  input  1  system clock, all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 rx  input  1  asynchronous MIDI serial line, idle high.
REQ-007 note_valid  output  1  one-cycle pulse when a complete note message is decoded.
REQ-008 note_on  output  1  1 = note-on, 0 = note-off; valid while note_valid is high and held afterwards.
REQ-009 note  output  7  note number of the last reported message.
REQ-010 velocity  output  7  velocity of the last reported message.
REQ-011 framing_err  output  1  one-cycle pulse when a byte has stop bit = 0.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer before any use.
REQ-013 UART RX SHALL leave IDLE on a synchronized 1->0 transition and sample start at CLKS_PER_BIT/2 clocks later; start sampled 1 -> return to IDLE, no byte.
REQ-014 SHALL sample 8 data bits LSB first, each CLKS_PER_BIT clocks after the previous sample, then the stop bit one CLKS_PER_BIT later.
REQ-015 Stop = 1 -> byte delivered to parser on the stop-sample cycle; stop = 0 -> byte discarded, framing_err pulses that cycle, parser state unchanged.
REQ-016 After the stop sample the receiver SHALL return to IDLE and accept a new start edge immediately (back-to-back bytes supported).
REQ-017 Parser states: WAIT_STATUS, WAIT_NOTE, WAIT_VEL; reset state WAIT_STATUS.
REQ-018 Status 0x8n or 0x9n with n == MIDI_CHANNEL -> store type, go to WAIT_NOTE, from any state (aborts any partial message).
REQ-019 Any other status 0x80-0xEF, or 0xF0-0xF7 -> clear stored type, go to WAIT_STATUS.
REQ-020 Real-time bytes 0xF8-0xFF SHALL be ignored with no state or register change, including mid-message.
REQ-021 Data byte (bit7 = 0) in WAIT_STATUS -> discarded unless REQ-029 applies.
REQ-022 Data byte in WAIT_NOTE -> captured as note, go to WAIT_VEL.
REQ-023 Data byte in WAIT_VEL -> note_valid pulses exactly one cycle after the velocity byte's stop-sample cycle; note/velocity/note_on updated in that same cycle.
REQ-024 note_on = 1 only for type 0x9n with velocity != 0; 0x9n with velocity 0 reported as note_on = 0, velocity 0.
REQ-025 After a reported message the parser SHALL return to WAIT_NOTE if running status is enabled, otherwise WAIT_STATUS.
REQ-026 note, velocity, note_on SHALL hold their values between note_valid pulses.

Reset
REQ-027 On rst high: note_valid, note_on, note, velocity, framing_err = 0; synchronizer flops = 1; UART in IDLE with counters 0; parser in WAIT_STATUS with stored type cleared.
REQ-028 rst asserted mid-byte SHALL discard the partial byte; after release the first complete start bit begins a fresh byte.

Configuration
REQ-029 Macro MIDI_RX_RUNNING_STATUS_EN defined: stored type persists after a message (REQ-025 -> WAIT_NOTE) and a data byte in WAIT_STATUS with a stored type is treated as note (-> WAIT_VEL); undefined: every message requires its own status byte and data bytes without one are discarded.

Verification
REQ-030 Bytes 0x90,0x3C,0x64 at 31250 baud -> one note_valid, note_on=1, note=0x3C, velocity=0x64, 1 cycle after third stop sample.
REQ-031 0x80,0x40,0x00 then 0x90,0x40,0x00 -> two pulses, both note_on=0, note=0x40, velocity=0.
REQ-032 0x91,0x3C,0x64 with MIDI_CHANNEL=0 -> no note_valid; following 0x90,0x3E,0x50 -> one pulse note=0x3E.
REQ-033 0x90,0x3C,0xF8,0x64 -> one pulse note=0x3C, velocity=0x64 (real-time ignored); 0x90,0x3C,0x90,0x3E,0x20 -> one pulse note=0x3E.
REQ-034 Byte 0x55 with stop bit driven 0 -> framing_err one pulse, no note_valid; rst mid-byte then 0x90,0x30,0x10 -> one pulse note=0x30.
REQ-035 0x90,0x3C,0x64,0x3E,0x50 -> with MIDI_RX_RUNNING_STATUS_EN two pulses (0x3C/0x64, 0x3E/0x50); without, one pulse (0x3C/0x64).
